quad_decoder: RTL

- x4 quadrature decoder: samples encoder channels a/b, decodes Gray-code phase transitions into up/down steps and keeps a loadable position counter.
- Receiving end of a rotary/linear encoder interface; position feeds the counter and datapath blocks.
- Includes input synchronizers, a start-up priming state, illegal-transition detection and a sticky error flag.

---
 rtl/quad_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronizes a/b, decodes Gray steps into a loadable position counter.
// Latency: SYNC_STAGES cycles from input capture to count/step/dir; no backpressure (free-running).
module quad_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             ld,
  input  logic [WIDTH-1:0] data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);

  typedef enum logic {
    PRIME = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       cur;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  logic [1:0]       delta;
  logic             is_up;
  logic             is_dn;
  logic             is_ill;
  logic             tracking;

  // Gray phase (AB) to its position on the up sequence 00,01,11,10.
  function automatic logic [1:0] phase_idx(input logic [1:0] ab);
    phase_idx = {ab[1], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b};
  end

  assign cur = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PRIME;
      prime_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  // Priming holds until the synchronizer has filled from its reset zeros, so
  // the phase present at release is adopted as prev rather than seen as a jump.
  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    case (state_q)
      PRIME: begin
        if (prime_cnt_q == PRIME_LAST) begin
          state_d = TRACK;
        end else begin
          prime_cnt_d = prime_cnt_q + PW'(1);
        end
      end
      TRACK: begin
        state_d = TRACK;
      end
      default: begin
        state_d = PRIME;
      end
    endcase
  end

  always_comb begin
    tracking = (state_q == TRACK);
    delta    = phase_idx(cur) - phase_idx(prev_q);
    is_up    = tracking && (delta == 2'd1);
    is_dn    = tracking && (delta == 2'd3);
    is_ill   = tracking && (delta == 2'd2);
  end

  // Output/datapath logic; load beats any concurrent step, illegal set beats clear.
  always_comb begin
    prev_d  = cur;
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;

    if (ld) begin
      count_d = data;
    end else if (is_up) begin
      count_d = count_q + WIDTH'(1);
      dir_d   = 1'b1;
      step_d  = 1'b1;
    end else if (is_dn) begin
      count_d = count_q - WIDTH'(1);
      dir_d   = 1'b0;
      step_d  = 1'b1;
    end

    if (is_ill) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      prev_q   <= 2'b00;
      count_q  <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      prev_q   <= prev_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule
